ibex_mem_arbiter: RTL and testbench

//  Shares one single-port SRAM (1-cycle read latency) between the Ibex instruction and data

---
 rtl/ibex_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ibex_mem_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ibex_mem_arbiter.sv
// Arbitrates the Ibex instruction and data ports onto one single-port SRAM with 1-cycle read latency.
// Data requests have priority, and a starvation counter bounds how long instruction fetch can be held off.
module ibex_mem_arbiter #(
    parameter logic [31:0] MemStart    = 32'h0000_0000,
    parameter int unsigned MemSize     = 131072,
    parameter int unsigned StarveLimit = 4,
    localparam int unsigned MemAw      = $clog2(MemSize / 4)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             instr_req_i,
    input  logic [31:0]      instr_addr_i,
    output logic             instr_gnt_o,
    output logic             instr_rvalid_o,
    output logic [31:0]      instr_rdata_o,
    output logic             instr_err_o,
    input  logic             data_req_i,
    input  logic             data_we_i,
    input  logic [3:0]       data_be_i,
    input  logic [31:0]      data_addr_i,
    input  logic [31:0]      data_wdata_i,
    output logic             data_gnt_o,
    output logic             data_rvalid_o,
    output logic [31:0]      data_rdata_o,
    output logic             data_err_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [3:0]       mem_be_o,
    output logic [MemAw-1:0] mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i
);

    localparam int unsigned SW = $clog2(StarveLimit + 1);

    typedef enum logic [1:0] {
        RSP_NONE  = 2'd0,
        RSP_INSTR = 2'd1,
        RSP_DATA  = 2'd2
    } rsp_e;

    rsp_e          rsp_q, rsp_d;
    logic          err_q, err_d;
    logic          wr_q, wr_d;
    logic          ready_q, ready_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;

    logic [31:0]   instr_off_s, data_off_s;
    logic          instr_in_range_s, data_in_range_s;
    logic          instr_win_s, data_win_s;
    logic          unused_s;

    // Window decode, arbitration and next-state computation.
    always_comb begin
        instr_off_s      = instr_addr_i - MemStart;
        data_off_s       = data_addr_i - MemStart;
        instr_in_range_s = (instr_off_s < 32'(MemSize));
        data_in_range_s  = (data_off_s < 32'(MemSize));

        instr_win_s = 1'b0;
        data_win_s  = 1'b0;
        // Grants are held off during reset and for one cycle after it.
        if (rst_i || !ready_q) begin
            instr_win_s = 1'b0;
            data_win_s  = 1'b0;
        end else if (instr_req_i && data_req_i) begin
            if (starve_cnt_q == SW'(StarveLimit)) begin
                instr_win_s = 1'b1;
            end else begin
                data_win_s = 1'b1;
            end
        end else if (instr_req_i) begin
            instr_win_s = 1'b1;
        end else if (data_req_i) begin
            data_win_s = 1'b1;
        end else begin
            instr_win_s = 1'b0;
            data_win_s  = 1'b0;
        end

        starve_cnt_d = starve_cnt_q;
        if (!instr_req_i || instr_win_s || !ready_q) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < SW'(StarveLimit)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end

        rsp_d   = RSP_NONE;
        err_d   = 1'b0;
        wr_d    = 1'b0;
        ready_d = 1'b1;
        if (instr_win_s) begin
            rsp_d = RSP_INSTR;
            err_d = !instr_in_range_s;
        end else if (data_win_s) begin
            rsp_d = RSP_DATA;
            err_d = !data_in_range_s;
            wr_d  = data_we_i;
        end else begin
            rsp_d = RSP_NONE;
        end
    end

    // SRAM command: zero unless a granted access lies inside the window.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;
        if (instr_win_s && instr_in_range_s) begin
            mem_req_o  = 1'b1;
            mem_be_o   = 4'hF;
            mem_addr_o = instr_off_s[MemAw+1:2];
        end else if (data_win_s && data_in_range_s) begin
            mem_req_o   = 1'b1;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_off_s[MemAw+1:2];
            mem_wdata_o = data_wdata_i;
        end else begin
            mem_req_o = 1'b0;
        end
    end

    // Response steering; SRAM data passes only to a successful read owner.
    always_comb begin
        instr_rvalid_o = !rst_i && (rsp_q == RSP_INSTR);
        data_rvalid_o  = !rst_i && (rsp_q == RSP_DATA);
        instr_err_o    = instr_rvalid_o && err_q;
        data_err_o     = data_rvalid_o && err_q;
        instr_rdata_o  = 32'h0;
        data_rdata_o   = 32'h0;
        if (instr_rvalid_o && !err_q) begin
            instr_rdata_o = mem_rdata_i;
        end else if (data_rvalid_o && !err_q && !wr_q) begin
            data_rdata_o = mem_rdata_i;
        end else begin
            instr_rdata_o = 32'h0;
            data_rdata_o  = 32'h0;
        end
    end

    assign instr_gnt_o = instr_win_s;
    assign data_gnt_o  = data_win_s;
    assign unused_s    = ^{instr_off_s, data_off_s};

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_q        <= RSP_NONE;
            err_q        <= 1'b0;
            wr_q         <= 1'b0;
            ready_q      <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            rsp_q        <= rsp_d;
            err_q        <= err_d;
            wr_q         <= wr_d;
            ready_q      <= ready_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Directed bench for ibex_mem_arbiter: a default-window instance plus one based at 0x1000
// to exercise address wrap below the base.
module tb_ibex_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req, data_req, data_we;
    logic [31:0] instr_addr, data_addr, data_wdata;
    logic [3:0]  data_be;

    logic        instr_gnt, instr_rvalid, instr_err, data_gnt, data_rvalid, data_err;
    logic [31:0] instr_rdata, data_rdata, mem_wdata, mem_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [14:0] mem_addr;

    logic        b_instr_gnt, b_instr_rvalid, b_instr_err, b_data_gnt, b_data_rvalid, b_data_err;
    logic [31:0] b_instr_rdata, b_data_rdata, b_mem_wdata;
    logic [31:0] b_mem_rdata = 32'h1234_5678;
    logic        b_mem_req, b_mem_we;
    logic [3:0]  b_mem_be;
    logic [14:0] b_mem_addr;

    int tests = 0;
    int fails = 0;
    logic prev_i, exp_i;

    always #5 clk = ~clk;

    // SRAM model: read data encodes the word address, anything else returns a marker.
    always_ff @(posedge clk) begin
        if (mem_req && !mem_we) mem_rdata <= 32'hC0DE_0000 | 32'(mem_addr);
        else                    mem_rdata <= 32'hBAD0_BAD0;
    end

    ibex_mem_arbiter u_dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
        .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
        .data_rdata_o(data_rdata), .data_err_o(data_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    ibex_mem_arbiter #(.MemStart(32'h0000_1000)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(b_instr_gnt),
        .instr_rvalid_o(b_instr_rvalid), .instr_rdata_o(b_instr_rdata), .instr_err_o(b_instr_err),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_gnt_o(b_data_gnt), .data_rvalid_o(b_data_rvalid),
        .data_rdata_o(b_data_rdata), .data_err_o(b_data_err),
        .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_be_o(b_mem_be), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; instr_req = 1'b1; instr_addr = 32'h80;
        data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
        step();
        chk("rst_instr_gnt", instr_gnt, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_instr_rvalid", instr_rvalid, 1'b0);
        instr_req = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_rvalid", instr_rvalid | data_rvalid, 1'b0);
        step();

        // 1: lone instruction read
        instr_req = 1'b1; instr_addr = 32'h80;
        #1;
        chk("t1_instr_gnt", instr_gnt, 1'b1);
        chk("t1_data_gnt", data_gnt, 1'b0);
        chk("t1_mem_req", mem_req, 1'b1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h20);
        chk("t1_mem_we_be", {mem_we, mem_be}, 5'h0F);
        step();
        instr_req = 1'b0;
        chk("t1_instr_rvalid", instr_rvalid, 1'b1);
        chk("t1_instr_rdata", instr_rdata, 32'hC0DE_0020);
        chk("t1_instr_err", instr_err, 1'b0);
        chk("t1_data_rvalid", data_rvalid, 1'b0);

        // 2: data write
        data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF;
        #1;
        chk("t2_data_gnt", data_gnt, 1'b1);
        chk("t2_mem_we", mem_we, 1'b1);
        chk("t2_mem_be", 32'(mem_be), 32'h3);
        chk("t2_mem_addr", 32'(mem_addr), 32'h40);
        chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        step();
        data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_wdata = 32'h0;
        chk("t2_data_rvalid", data_rvalid, 1'b1);
        chk("t2_data_err", data_err, 1'b0);
        chk("t2_data_rdata", data_rdata, 32'h0);
        chk("t2_instr_rvalid", instr_rvalid, 1'b0);

        // 3: both requesting continuously -> D,D,D,D,I repeating
        instr_req = 1'b1; instr_addr = 32'h10;
        data_req = 1'b1; data_be = 4'hF; data_addr = 32'h200;
        prev_i = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            exp_i = ((i % 5) == 4);
            chk($sformatf("t3_instr_gnt_%0d", i), instr_gnt, exp_i);
            chk($sformatf("t3_data_gnt_%0d", i), data_gnt, !exp_i);
            chk($sformatf("t3_mem_addr_%0d", i), 32'(mem_addr), exp_i ? 32'h4 : 32'h80);
            if (i > 0) begin
                chk($sformatf("t3_instr_rvalid_%0d", i), instr_rvalid, prev_i);
                chk($sformatf("t3_data_rvalid_%0d", i), data_rvalid, !prev_i);
                chk($sformatf("t3_rdata_%0d", i), instr_rdata | data_rdata,
                    prev_i ? 32'hC0DE_0004 : 32'hC0DE_0080);
            end
            prev_i = exp_i;
            step();
        end
        instr_req = 1'b0; data_req = 1'b0;
        chk("t3_last_instr_rvalid", instr_rvalid, prev_i);

        // 4: data read just past the window
        data_req = 1'b1; data_addr = 32'h0002_0000;
        #1;
        chk("t4_data_gnt", data_gnt, 1'b1);
        chk("t4_mem_req", mem_req, 1'b0);
        chk("t4_mem_addr", 32'(mem_addr), 32'h0);
        step();
        data_req = 1'b0;
        chk("t4_data_rvalid", data_rvalid, 1'b1);
        chk("t4_data_err", data_err, 1'b1);
        chk("t4_data_rdata", data_rdata, 32'h0);

        // 5: instruction read one word below a 0x1000 base wraps out of range
        instr_req = 1'b1; instr_addr = 32'h0000_0FFC;
        #1;
        chk("t5_b_instr_gnt", b_instr_gnt, 1'b1);
        chk("t5_b_mem_req", b_mem_req, 1'b0);
        step();
        instr_req = 1'b0;
        chk("t5_b_instr_rvalid", b_instr_rvalid, 1'b1);
        chk("t5_b_instr_err", b_instr_err, 1'b1);
        chk("t5_b_instr_rdata", b_instr_rdata, 32'h0);
        chk("t5_a_instr_err", instr_err, 1'b0);
        chk("t5_a_instr_rdata", instr_rdata, 32'hC0DE_03FF);

        // 6: reset with a response in flight and a partly starved instruction port
        instr_req = 1'b1; instr_addr = 32'h80;
        data_req = 1'b1; data_addr = 32'h200;
        #1;
        chk("t6_pre_data_gnt0", data_gnt, 1'b1);
        step();
        chk("t6_pre_data_gnt1", data_gnt, 1'b1);
        step();
        rst = 1'b1;
        #1;
        chk("t6_rst_data_rvalid", data_rvalid, 1'b0);
        chk("t6_rst_gnt", instr_gnt | data_gnt, 1'b0);
        chk("t6_rst_mem_req", mem_req, 1'b0);
        step();
        rst = 1'b0;
        #1;
        chk("t6_post_gnt", instr_gnt | data_gnt, 1'b0);
        chk("t6_post_rvalid", instr_rvalid | data_rvalid, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            exp_i = (i == 4);
            chk($sformatf("t6_instr_gnt_%0d", i), instr_gnt, exp_i);
            chk($sformatf("t6_data_gnt_%0d", i), data_gnt, !exp_i);
            step();
        end
        instr_req = 1'b0; data_req = 1'b0;
        chk("t6_final_instr_rvalid", instr_rvalid, 1'b1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
